mcp_master: RTL and testbench

//  CPU-side initiator for the Memory Card Port. Converts 32-bit CPU bus requests
//  (already decoded to the E800_0000..EFFF_FFFF window) into byte-wide MCP cycles.

---
 rtl/mcp_master_if.sv | 29 ++
 rtl/mcp_master.sv | 230 +++++++++++++++++++++++
 tb/tb_mcp_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp_master_if.sv
// Memory Card Port initiator bus bundle: CPU-side request channel plus the byte-wide port pins.
// master is the view of mcp_master; slave is the view of the CPU/responder side.
interface mcp_master_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [26:2] cpu_a;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_di;
  logic [31:0] cpu_do;
  logic        cpu_ack;
  logic        cpu_timeout;
  logic [26:1] mcp_a;
  logic [7:0]  mcp_do;
  logic [7:0]  mcp_di;
  logic        mcp_csn;
  logic        mcp_rdn;
  logic        mcp_wrn;
  logic        mcp_readyn;

  modport master (
    input  cpu_req, cpu_wr, cpu_a, cpu_be, cpu_di, mcp_di, mcp_readyn,
    output cpu_do, cpu_ack, cpu_timeout, mcp_a, mcp_do, mcp_csn, mcp_rdn, mcp_wrn
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_a, cpu_be, cpu_di, mcp_di, mcp_readyn,
    input  cpu_do, cpu_ack, cpu_timeout, mcp_a, mcp_do, mcp_csn, mcp_rdn, mcp_wrn
  );
endinterface

// File: rtl/mcp_master.sv
// CPU-side Memory Card Port initiator: splits a 32-bit request into up to two
// byte-wide port cycles (one per enabled halfword) with setup/strobe/hold timing.
module mcp_master #(
  parameter int T_SETUP      = 1,
  parameter int T_STROBE_MIN = 2,
  parameter int T_HOLD       = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          reset,
  mcp_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam logic [15:0] SETUP_C   = 16'(T_SETUP);
  localparam logic [15:0] STR_MIN_C = 16'(T_STROBE_MIN);
  localparam logic [15:0] HOLD_C    = 16'(T_HOLD);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [26:2] a_r, a_s;
  logic        hi_pend_r, hi_pend_s;
  logic [7:0]  di_hi_r, di_hi_s;
  logic        wr_r, wr_s;
  logic        h_r, h_s;
  logic [26:1] mcp_a_r, mcp_a_s;
  logic [7:0]  mcp_do_r, mcp_do_s;
  logic        csn_r, csn_s;
  logic        rdn_r, rdn_s;
  logic        wrn_r, wrn_s;
  logic [31:0] cpu_do_r, cpu_do_s;
  logic        ack_r, ack_s;
  logic        timeout_r, timeout_s;

  // Only the low byte of each halfword travels over the port; the upper byte reads as FF.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic h, input logic [7:0] b);
    logic [31:0] r;
    r = w;
    if (h) begin
      r[23:16] = b;
    end else begin
      r[7:0] = b;
    end
    return r;
  endfunction

  // Next-state and next-output logic for the port cycle sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    a_s       = a_r;
    hi_pend_s = hi_pend_r;
    di_hi_s   = di_hi_r;
    wr_s      = wr_r;
    h_s       = h_r;
    mcp_a_s   = mcp_a_r;
    mcp_do_s  = mcp_do_r;
    csn_s     = csn_r;
    rdn_s     = rdn_r;
    wrn_s     = wrn_r;
    cpu_do_s  = cpu_do_r;
    ack_s     = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cpu_req && !ack_r) begin
          a_s       = bus.cpu_a;
          hi_pend_s = |bus.cpu_be[3:2];
          di_hi_s   = bus.cpu_di[23:16];
          wr_s      = bus.cpu_wr;
          cpu_do_s  = 32'hFFFF_FFFF;
          cnt_s     = 16'd1;
          if (|bus.cpu_be[1:0]) begin
            h_s     = 1'b0;
            state_s = SETUP;
            csn_s   = 1'b0;
            mcp_a_s = {bus.cpu_a, 1'b0};
            if (bus.cpu_wr) begin
              mcp_do_s = bus.cpu_di[7:0];
            end else begin
              mcp_do_s = mcp_do_r;
            end
          end else if (|bus.cpu_be[3:2]) begin
            h_s     = 1'b1;
            state_s = SETUP;
            csn_s   = 1'b0;
            mcp_a_s = {bus.cpu_a, 1'b1};
            if (bus.cpu_wr) begin
              mcp_do_s = bus.cpu_di[23:16];
            end else begin
              mcp_do_s = mcp_do_r;
            end
          end else begin
            // Nothing enabled: a bare GAP cycle turns the request straight into an ACK.
            h_s     = 1'b0;
            state_s = GAP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r >= SETUP_C) begin
          state_s = STROBE;
          cnt_s   = 16'd1;
          if (wr_r) begin
            wrn_s = 1'b0;
          end else begin
            rdn_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      STROBE: begin
        if ((cnt_r >= STR_MIN_C) && !bus.mcp_readyn) begin
          state_s = HOLD;
          cnt_s   = 16'd1;
          rdn_s   = 1'b1;
          wrn_s   = 1'b1;
          if (!wr_r) begin
            cpu_do_s = put_byte(cpu_do_r, h_r, bus.mcp_di);
          end else begin
            cpu_do_s = cpu_do_r;
          end
        end else if (cnt_r >= TIMEOUT_C) begin
          // Responder never answered: finish the cycle anyway and flag it.
          state_s   = HOLD;
          cnt_s     = 16'd1;
          rdn_s     = 1'b1;
          wrn_s     = 1'b1;
          timeout_s = 1'b1;
          if (!wr_r) begin
            cpu_do_s = put_byte(cpu_do_r, h_r, 8'hFF);
          end else begin
            cpu_do_s = cpu_do_r;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      HOLD: begin
        if (cnt_r >= HOLD_C) begin
          state_s = GAP;
          csn_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      GAP: begin
        if (!h_r && hi_pend_r) begin
          h_s     = 1'b1;
          state_s = SETUP;
          csn_s   = 1'b0;
          cnt_s   = 16'd1;
          mcp_a_s = {a_r, 1'b1};
          if (wr_r) begin
            mcp_do_s = di_hi_r;
          end else begin
            mcp_do_s = mcp_do_r;
          end
        end else begin
          ack_s   = 1'b1;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        csn_s   = 1'b1;
        rdn_s   = 1'b1;
        wrn_s   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      a_r       <= 25'd0;
      hi_pend_r <= 1'b0;
      di_hi_r   <= 8'd0;
      wr_r      <= 1'b0;
      h_r       <= 1'b0;
      mcp_a_r   <= 26'd0;
      mcp_do_r  <= 8'd0;
      csn_r     <= 1'b1;
      rdn_r     <= 1'b1;
      wrn_r     <= 1'b1;
      cpu_do_r  <= 32'hFFFF_FFFF;
      ack_r     <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      a_r       <= a_s;
      hi_pend_r <= hi_pend_s;
      di_hi_r   <= di_hi_s;
      wr_r      <= wr_s;
      h_r       <= h_s;
      mcp_a_r   <= mcp_a_s;
      mcp_do_r  <= mcp_do_s;
      csn_r     <= csn_s;
      rdn_r     <= rdn_s;
      wrn_r     <= wrn_s;
      cpu_do_r  <= cpu_do_s;
      ack_r     <= ack_s;
      timeout_r <= timeout_s;
    end
  end

  assign bus.cpu_do      = cpu_do_r;
  assign bus.cpu_ack     = ack_r;
  assign bus.cpu_timeout = timeout_r;
  assign bus.mcp_a       = mcp_a_r;
  assign bus.mcp_do      = mcp_do_r;
  assign bus.mcp_csn     = csn_r;
  assign bus.mcp_rdn     = rdn_r;
  assign bus.mcp_wrn     = wrn_r;

endmodule

// File: tb/tb_mcp_master.sv
// Directed bench for mcp_master: hand-computed latencies, port addresses/data,
// read-back words, timeout and reset-abort behaviour, plus per-cycle pin rules.
module tb_mcp_master;
  logic clk = 1'b0;
  logic reset;
  mcp_master_if bus ();

  mcp_master dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results of the most recent transaction
  int          lat;
  logic [31:0] rdata;
  int          n_str;
  int          str_len [4];
  logic [25:0] str_a   [4];
  logic [7:0]  str_do  [4];
  int          to_cnt;
  int          viol;
  int          rd_low;
  int          wr_low;
  int          gap_len;
  int          csn_lows;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and act as the responder until ACK or the cycle bound.
  // wait_c: 0 = READYn tied low, >0 = extra wait cycles, <0 = READYn stuck high.
  task automatic run(input logic wr, input logic [24:0] a, input logic [3:0] be,
                     input logic [31:0] di, input logic [7:0] rbyte, input int wait_c,
                     input int bound);
    int          c;
    int          gap_run;
    bit          had_low;
    bit          in_str;
    bit          str;
    logic        p_csn;
    logic [25:0] p_a;
    logic [7:0]  p_do;
    lat = -1; rdata = 32'h0; n_str = 0; to_cnt = 0; viol = 0;
    rd_low = 0; wr_low = 0; gap_len = 0; csn_lows = 0;
    for (int i = 0; i < 4; i++) begin
      str_len[i] = 0; str_a[i] = 26'h0; str_do[i] = 8'h0;
    end
    c = 0; gap_run = 0; had_low = 1'b0; in_str = 1'b0;
    p_csn = 1'b1; p_a = 26'h0; p_do = 8'h0;
    bus.cpu_wr = wr; bus.cpu_a = a; bus.cpu_be = be; bus.cpu_di = di;
    bus.mcp_di = rbyte;
    bus.mcp_readyn = (wait_c == 0) ? 1'b0 : 1'b1;
    bus.cpu_req = 1'b1;
    for (int j = 0; j <= bound && lat < 0; j++) begin
      tick();
      str = !bus.mcp_rdn || !bus.mcp_wrn;
      if (!bus.mcp_rdn) rd_low++;
      if (!bus.mcp_wrn) wr_low++;
      if (!bus.mcp_rdn && !bus.mcp_wrn) viol++;
      if (str && bus.mcp_csn) viol++;
      if (!bus.mcp_csn && !p_csn && (bus.mcp_a !== p_a || bus.mcp_do !== p_do)) viol++;
      if (str) begin
        if (!in_str) begin
          c = 0;
          if (n_str < 4) begin
            str_a[n_str] = bus.mcp_a;
            str_do[n_str] = bus.mcp_do;
          end
        end
        c++;
      end else if (in_str) begin
        if (n_str < 4) str_len[n_str] = c;
        n_str++;
      end
      in_str = str;
      if (wait_c < 0) bus.mcp_readyn = 1'b1;
      else if (wait_c == 0) bus.mcp_readyn = 1'b0;
      else bus.mcp_readyn = (str && c >= 2 + wait_c) ? 1'b0 : 1'b1;
      if (!bus.mcp_csn && p_csn) begin
        csn_lows++;
        if (had_low) gap_len = gap_run;
        gap_run = 0;
      end
      if (bus.mcp_csn && had_low) gap_run++;
      if (!bus.mcp_csn) had_low = 1'b1;
      if (bus.cpu_timeout) to_cnt++;
      p_csn = bus.mcp_csn; p_a = bus.mcp_a; p_do = bus.mcp_do;
      if (bus.cpu_ack) begin
        lat = j;
        rdata = bus.cpu_do;
        bus.cpu_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    logic [4:0] pat;
    int         csn_seen;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_a = 25'h0; bus.cpu_be = 4'h0;
    bus.cpu_di = 32'h0; bus.mcp_di = 8'h0; bus.mcp_readyn = 1'b1;
    tick();
    tick();
    check("rst_csn", bus.mcp_csn, 1'b1);
    check("rst_rdn", bus.mcp_rdn, 1'b1);
    check("rst_wrn", bus.mcp_wrn, 1'b1);
    check("rst_mcp_a", bus.mcp_a, 26'h0);
    check("rst_mcp_do", bus.mcp_do, 8'h0);
    check("rst_cpu_do", bus.cpu_do, 32'hFFFF_FFFF);
    check("rst_ack", bus.cpu_ack, 1'b0);
    check("rst_timeout", bus.cpu_timeout, 1'b0);
    reset = 1'b0;
    tick();

    // Single low-halfword read
    run(1'b0, 25'h0000001, 4'b0011, 32'h0, 8'h5A, 0, 40);
    check("t1_lat", lat, 5);
    check("t1_rdata", rdata, 32'hFFFF_FF5A);
    check("t1_nstr", n_str, 1);
    check("t1_addr", str_a[0], 26'h0000002);
    check("t1_strlen", str_len[0], 2);
    check("t1_csn_lows", csn_lows, 1);
    check("t1_no_wr", wr_low, 0);
    check("t1_no_to", to_cnt, 0);
    check("t1_proto", viol, 0);
    tick();
    check("t1_ack_pulse", bus.cpu_ack, 1'b0);

    // Full-word write: two port cycles separated by a one-cycle CSn gap
    run(1'b1, 25'h0ABCDEF, 4'b1111, 32'h00AB_00CD, 8'h00, 0, 40);
    check("t2_lat", lat, 10);
    check("t2_nstr", n_str, 2);
    check("t2_addr0", str_a[0], 26'h1579BDE);
    check("t2_do0", str_do[0], 8'hCD);
    check("t2_addr1", str_a[1], 26'h1579BDF);
    check("t2_do1", str_do[1], 8'hAB);
    check("t2_gap", gap_len, 1);
    check("t2_csn_lows", csn_lows, 2);
    check("t2_no_rd", rd_low, 0);
    check("t2_rdata", rdata, 32'hFFFF_FFFF);
    check("t2_proto", viol, 0);
    tick();

    // Responder adds four wait cycles
    run(1'b0, 25'h0000001, 4'b0011, 32'h0, 8'h3C, 4, 40);
    check("t3_strlen", str_len[0], 6);
    check("t3_lat", lat, 9);
    check("t3_no_to", to_cnt, 0);
    check("t3_rdata", rdata, 32'hFFFF_FF3C);
    tick();

    // High halfword only
    run(1'b0, 25'h1FFFFFF, 4'b1100, 32'h0, 8'h77, 0, 40);
    check("t3b_lat", lat, 5);
    check("t3b_rdata", rdata, 32'hFF77_FFFF);
    check("t3b_addr", str_a[0], 26'h3FFFFFF);
    check("t3b_nstr", n_str, 1);
    tick();

    // Both halfwords read, enabled by one bit each
    run(1'b0, 25'h0000040, 4'b1001, 32'h0, 8'hC3, 0, 40);
    check("t3c_lat", lat, 10);
    check("t3c_rdata", rdata, 32'hFFC3_FFC3);
    check("t3c_nstr", n_str, 2);
    check("t3c_proto", viol, 0);
    tick();

    // No byte enables: immediate ACK, data word reset to all ones
    run(1'b0, 25'h0000007, 4'b0000, 32'h0, 8'h11, 0, 40);
    check("t5_lat", lat, 1);
    check("t5_csn_lows", csn_lows, 0);
    check("t5_nstr", n_str, 0);
    check("t5_rdata", rdata, 32'hFFFF_FFFF);
    tick();

    // Request held high: not re-accepted in the ACK cycle, only one later
    bus.cpu_be = 4'b0000; bus.cpu_req = 1'b1;
    pat = 5'b0; csn_seen = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      pat[j] = bus.cpu_ack;
      if (!bus.mcp_csn) csn_seen++;
    end
    bus.cpu_req = 1'b0;
    check("t5b_ack_pattern", pat, 5'b10010);
    check("t5b_no_csn", csn_seen, 0);
    tick();
    check("t5b_ack_low", bus.cpu_ack, 1'b0);

    // READYn stuck high: forced completion after the timeout
    run(1'b0, 25'h0000003, 4'b0011, 32'h0, 8'h00, -1, 400);
    check("t4_strlen", str_len[0], 255);
    check("t4_to_pulse", to_cnt, 1);
    check("t4_rdata", rdata, 32'hFFFF_FFFF);
    check("t4_lat", lat, 258);
    check("t4_proto", viol, 0);
    tick();
    check("t4_to_low", bus.cpu_timeout, 1'b0);

    // Reset in the middle of a strobe aborts the cycle without ACK
    bus.cpu_wr = 1'b0; bus.cpu_a = 25'h1; bus.cpu_be = 4'b0011;
    bus.mcp_di = 8'h99; bus.mcp_readyn = 1'b0; bus.cpu_req = 1'b1;
    tick();
    tick();
    check("t6_in_strobe", bus.mcp_rdn, 1'b0);
    reset = 1'b1; bus.cpu_req = 1'b0;
    tick();
    check("t6_csn", bus.mcp_csn, 1'b1);
    check("t6_rdn", bus.mcp_rdn, 1'b1);
    check("t6_wrn", bus.mcp_wrn, 1'b1);
    check("t6_ack", bus.cpu_ack, 1'b0);
    check("t6_cpu_do", bus.cpu_do, 32'hFFFF_FFFF);
    check("t6_mcp_a", bus.mcp_a, 26'h0);
    reset = 1'b0;
    tick();
    tick();
    check("t6_no_late_ack", bus.cpu_ack, 1'b0);
    check("t6_idle_csn", bus.mcp_csn, 1'b1);
    run(1'b0, 25'h0000005, 4'b0011, 32'h0, 8'hA5, 0, 40);
    check("t6_after_lat", lat, 5);
    check("t6_after_rdata", rdata, 32'hFFFF_FFA5);
    check("t6_after_addr", str_a[0], 26'h000000A);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
